// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
// Round-robin scheduler in front of a shared WIDTH-bit register. One winner
// per grant window is loaded into q and acknowledged with a one-cycle gnt.
// Every grant is followed by a single GAP edge. During that edge req is
// ignored, so a requester that is still high in its grant cycle is not
// served twice.

module dff_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       q,
   output logic                   q_valid,
   output logic [IDX_W-1:0]       owner,
   output logic                   busy
);

   localparam int unsigned NR = unsigned'(N_REQ);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GAP  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_nxt;

   logic [N_REQ-1:0]  r_gnt;
   logic [N_REQ-1:0]  w_gnt_nxt;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  w_q_nxt;
   logic              r_q_valid;
   logic              w_q_valid_nxt;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  w_owner_nxt;
   logic              r_busy;
   logic              w_busy_nxt;

   logic              w_found;
   logic [IDX_W-1:0]  w_win;
   logic              w_grant;
   logic [WIDTH-1:0]  w_win_data;

   // Round-robin search: the first requester found at or after r_ptr, with wrap-around
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         int unsigned idx;
         idx = (int'(r_ptr) + k) % NR;
         if (!w_found && req[idx[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = idx[IDX_W-1:0];
         end
      end
   end

   // A grant happens only on an IDLE edge that has at least one request
   always_comb begin
      w_grant = (r_state == S_IDLE) && w_found;
   end

   // Select the winner's data word from the packed wdata bus
   always_comb begin
      w_win_data = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         if (k[IDX_W-1:0] == w_win) begin
            w_win_data = wdata[k*WIDTH +: WIDTH];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE -> GAP on a grant, and GAP always returns to IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_grant ? S_GAP : S_IDLE;
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values: gnt and q_valid are pulses; q, owner and ptr hold unless granted
   always_comb begin
      w_gnt_nxt     = '0;
      w_q_valid_nxt = 1'b0;
      w_q_nxt       = r_q;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_busy_nxt    = (w_state_nxt == S_GAP);
      if (w_grant) begin
         for (int unsigned k = 0; k < NR; k++) begin
            w_gnt_nxt[k] = (k[IDX_W-1:0] == w_win);
         end
         w_q_valid_nxt = 1'b1;
         w_q_nxt       = w_win_data;
         w_owner_nxt   = w_win;
         w_ptr_nxt     = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      end
   end

   // Registered outputs, shared register and priority pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt     <= '0;
         r_q       <= '0;
         r_q_valid <= 1'b0;
         r_owner   <= '0;
         r_busy    <= 1'b0;
         r_ptr     <= '0;
      end else begin
         r_gnt     <= w_gnt_nxt;
         r_q       <= w_q_nxt;
         r_q_valid <= w_q_valid_nxt;
         r_owner   <= w_owner_nxt;
         r_busy    <= w_busy_nxt;
         r_ptr     <= w_ptr_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign q       = r_q;
   assign q_valid = r_q_valid;
   assign owner   = r_owner;
   assign busy    = r_busy;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Testbench for dff_share_arbiter: directed scenarios and a randomized run.
// The DUT is compared against a rotation-based reference model.

module tb_dff_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;
   localparam int VW = N + W + 1 + IW + 1;

   logic           clk   = 1'b0;
   logic           rst   = 1'b1;
   logic [N-1:0]   req   = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic           q_valid;
   logic [IW-1:0]  owner;
   logic           busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic           m_gap;
   int             m_ptr;
   logic [W-1:0]   m_q;
   logic [IW-1:0]  m_owner;
   logic [N-1:0]   m_gnt;
   logic           m_qv;

   dff_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata),
      .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] obs_vec();
      return {gnt, q, q_valid, owner, busy};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {m_gnt, m_q, m_qv, m_owner, m_gap};
   endfunction

   task automatic model_reset();
      m_gap = 1'b0; m_ptr = 0; m_q = '0; m_owner = '0; m_gnt = '0; m_qv = 1'b0;
   endtask

   // One clock edge of the spec's rules: rotate req so that ptr is bit 0 and take its lowest set bit
   task automatic model_edge();
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot, low;
      int             p, win;
      m_gnt = '0;
      m_qv  = 1'b0;
      if (m_gap) begin
         m_gap = 1'b0;
      end else if (req != '0) begin
         dbl   = {req, req};
         rot   = N'(dbl >> m_ptr);
         low   = rot & (~rot + 1'b1);
         p     = $clog2(low);
         win   = (m_ptr + p) % N;
         m_q     = wdata[win*W +: W];
         m_gnt   = N'(1) << win;
         m_qv    = 1'b1;
         m_owner = IW'(win);
         m_ptr   = (win + 1) % N;
         m_gap   = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      model_reset();
      #3;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL reset_initial: got %h expected %h", obs_vec(), {VW{1'b0}});
      end
      #1; rst = 1'b0; model_reset();
      req = 4'b0100; wdata = 32'h44332211;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_pregrant: got %h expected %h", obs_vec(), exp_vec());
      end
      req = 4'b1111;
      #2; rst = 1'b1; #1;
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL reset_async: got %h expected %h", obs_vec(), {VW{1'b0}});
      end
      model_reset();
      #1; rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0001 || q !== 8'h11 || owner !== 2'd0) begin
         errors++; $display("FAIL reset_first_grant: got gnt=%b q=%h owner=%0d expected gnt=0001 q=11 owner=0", gnt, q, owner);
      end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_single();
      req = 4'b0100; wdata = 32'h00A50000;
      tick();
      checks++;
      if (obs_vec() !== {4'b0100, 8'hA5, 1'b1, 2'd2, 1'b1}) begin
         errors++; $display("FAIL single_grant: got %h expected %h", obs_vec(), {4'b0100, 8'hA5, 1'b1, 2'd2, 1'b1});
      end
      tick();
      checks++;
      if (obs_vec() !== {4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0}) begin
         errors++; $display("FAIL single_gap: got %h expected %h", obs_vec(), {4'b0000, 8'hA5, 1'b0, 2'd2, 1'b0});
      end
      req = '0;
      tick();
      checks++;
      if (obs_vec() !== exp_vec() || gnt !== '0) begin
         errors++; $display("FAIL single_no_regrant: got %h expected %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req = 4'b1111; wdata = 32'h13121110;
      for (int i = 0; i < 10; i++) begin
         logic [N-1:0] eg;
         logic [W-1:0] eq;
         tick();
         eg = (i % 2 == 0) ? (N'(1) << ((i / 2) % 4)) : '0;
         eq = 8'h10 + W'(((i - (i % 2)) / 2) % 4);
         checks++;
         if (gnt !== eg || q !== eq || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rr_step%0d: got gnt=%b q=%h expected gnt=%b q=%h", i, gnt, q, eg, eq);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b1000; wdata = 32'h33000000;
      tick();
      checks++;
      if (gnt !== 4'b1000 || q !== 8'h33) begin
         errors++; $display("FAIL wrap_first: got gnt=%b q=%h expected gnt=1000 q=33", gnt, q);
      end
      req = 4'b0011; wdata = 32'h33002120;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0001 || owner !== 2'd0 || q !== 8'h20) begin
         errors++; $display("FAIL wrap_to_zero: got gnt=%b owner=%0d q=%h expected gnt=0001 owner=0 q=20", gnt, owner, q);
      end
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0010 || owner !== 2'd1 || q !== 8'h21) begin
         errors++; $display("FAIL wrap_then_one: got gnt=%b owner=%0d q=%h expected gnt=0010 owner=1 q=21", gnt, owner, q);
      end
      req = '0;
      tick();
   endtask

   task automatic test_withdrawn();
      do_reset();
      req = 4'b1011; wdata = 32'h43004140;
      tick();
      checks++;
      if (gnt !== 4'b0001 || q !== 8'h40) begin
         errors++; $display("FAIL withdraw_first: got gnt=%b q=%h expected gnt=0001 q=40", gnt, q);
      end
      req = 4'b1010;
      tick();
      req = 4'b1000;
      tick();
      checks++;
      if (obs_vec() !== {4'b1000, 8'h43, 1'b1, 2'd3, 1'b1}) begin
         errors++; $display("FAIL withdraw_grant3: got %h expected %h", obs_vec(), {4'b1000, 8'h43, 1'b1, 2'd3, 1'b1});
      end
      req = '0;
      tick();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (obs_vec() !== {4'b0000, 8'h43, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL idle_cycle%0d: got %h expected %h", i, obs_vec(), {4'b0000, 8'h43, 1'b0, 2'd3, 1'b0});
         end
      end
   endtask

   task automatic test_reset_gap();
      do_reset();
      req = 4'b0010; wdata = 32'h00005A00;
      tick();
      checks++;
      if (gnt !== 4'b0010 || q !== 8'h5A) begin
         errors++; $display("FAIL rstgap_grant: got gnt=%b q=%h expected gnt=0010 q=5a", gnt, q);
      end
      #2; rst = 1'b1; #1;
      checks++;
      if (obs_vec() !== '0) begin
         errors++; $display("FAIL rstgap_async: got %h expected %h", obs_vec(), {VW{1'b0}});
      end
      model_reset();
      req = 4'b0011; wdata = 32'h00008877;
      #1; rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0001 || q !== 8'h77 || owner !== 2'd0) begin
         errors++; $display("FAIL rstgap_ptr0: got gnt=%b q=%h owner=%0d expected gnt=0001 q=77 owner=0", gnt, q, owner);
      end
      req = '0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
            checks++;
            if (obs_vec() !== '0) begin
               errors++; $display("FAIL rand_reset%0d: got %h expected %h", i, obs_vec(), {VW{1'b0}});
            end
         end
         req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         wdata = $urandom;
         tick();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL rand_cycle%0d: got %h expected %h (req=%b)", i, obs_vec(), exp_vec(), req);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_withdrawn();
      test_idle();
      test_reset_gap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
